// File: rtl/dvga_pkg.sv
// Shared constants and helpers for the DVGA pixel pipeline: control bit
// positions, position-word field ranges and RGB555 -> RGB888 expansion.
package dvga_pkg;

  localparam int SPR_DIM  = 32;
  localparam int PIPE_LAT = 3;

  localparam int CTRL_SPR0_EN  = 0;
  localparam int CTRL_SPR1_EN  = 1;
  localparam int CTRL_COLL_CLR = 2;

  localparam int POS_X_LSB = 0;
  localparam int POS_X_MSB = 9;
  localparam int POS_Y_LSB = 16;
  localparam int POS_Y_MSB = 25;

  // Each 5-bit channel is widened by replicating its top bits into the LSBs,
  // so full-scale 5'h1f maps to 8'hff.
  function automatic logic [23:0] rgb555_to_888(input logic [14:0] c);
    return {c[14:10], c[14:12], c[9:5], c[9:7], c[4:0], c[4:2]};
  endfunction

endpackage

// File: rtl/dvga_delay_line.sv
// Fixed-depth shift register with synchronous reset; used to align timing
// and sprite-hit bookkeeping with the memory read latency.
module dvga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dvga_pixpipe.sv
// Palette lookup plus two 32x32 sprite overlays, 3-clock pixel pipeline.
// Optional sticky sprite collision flag built when DVGA_SPR_COLLIDE_EN is defined.
module dvga_pixpipe
  import dvga_pkg::*;
#(
  parameter int SPR_LOG2 = 5,
  parameter int XY_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            pix_dat_i,
  input  logic [XY_W-1:0]       pix_x_i,
  input  logic [XY_W-1:0]       pix_y_i,
  input  logic                  blank_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic [31:0]           ctrl_i,
  input  logic [31:0]           spr0_pos_i,
  input  logic [31:0]           spr1_pos_i,
  output logic [7:0]            pal0_adr_o,
  input  logic [31:0]           pal0_dat_i,
  output logic [2*SPR_LOG2-1:0] spr0_adr_o,
  input  logic [15:0]           spr0_dat_i,
  output logic [2*SPR_LOG2-1:0] spr1_adr_o,
  input  logic [15:0]           spr1_dat_i,
  output logic [23:0]           rgb_o,
  output logic                  blank_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  coll_o
);

  localparam int AW = 2 * SPR_LOG2;

  logic            vs_prev_q, vs_prev_d;
  logic [1:0]      sh_en_q, sh_en_d;
  logic [XY_W-1:0] sh_x0_q, sh_x0_d, sh_y0_q, sh_y0_d;
  logic [XY_W-1:0] sh_x1_q, sh_x1_d, sh_y1_q, sh_y1_d;
  logic [7:0]      pal_adr_q, pal_adr_d;
  logic [AW-1:0]   spr0_adr_q, spr0_adr_d, spr1_adr_q, spr1_adr_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d;

  logic [XY_W:0]   dx0, dy0, dx1, dy1;
  logic            hit0, hit1, vs_edge;
  logic            s2_blank, s2_hsync, s2_vsync, s2_hit0, s2_hit1;

  // Shadow copies change only at the vsync rising edge, so the pixel sampled
  // on that edge still sees the previous frame's settings.
  always_comb begin
    vs_edge   = vsync_i & ~vs_prev_q;
    vs_prev_d = vsync_i;
    sh_en_d   = sh_en_q;
    sh_x0_d   = sh_x0_q;
    sh_y0_d   = sh_y0_q;
    sh_x1_d   = sh_x1_q;
    sh_y1_d   = sh_y1_q;
    if (vs_edge) begin
      sh_en_d = {ctrl_i[CTRL_SPR1_EN], ctrl_i[CTRL_SPR0_EN]};
      sh_x0_d = spr0_pos_i[POS_X_MSB:POS_X_LSB];
      sh_y0_d = spr0_pos_i[POS_Y_MSB:POS_Y_LSB];
      sh_x1_d = spr1_pos_i[POS_X_MSB:POS_X_LSB];
      sh_y1_d = spr1_pos_i[POS_Y_MSB:POS_Y_LSB];
    end
  end

  // One extra bit on the subtraction gives the sign; the sprite never wraps
  // past the right/bottom edge of the coordinate space.
  always_comb begin
    dx0  = {1'b0, pix_x_i} - {1'b0, sh_x0_q};
    dy0  = {1'b0, pix_y_i} - {1'b0, sh_y0_q};
    dx1  = {1'b0, pix_x_i} - {1'b0, sh_x1_q};
    dy1  = {1'b0, pix_y_i} - {1'b0, sh_y1_q};
    hit0 = sh_en_q[0] && (dx0[XY_W:SPR_LOG2] == '0) && (dy0[XY_W:SPR_LOG2] == '0);
    hit1 = sh_en_q[1] && (dx1[XY_W:SPR_LOG2] == '0) && (dy1[XY_W:SPR_LOG2] == '0);
    pal_adr_d  = pix_dat_i;
    spr0_adr_d = hit0 ? {dy0[SPR_LOG2-1:0], dx0[SPR_LOG2-1:0]} : '0;
    spr1_adr_d = hit1 ? {dy1[SPR_LOG2-1:0], dx1[SPR_LOG2-1:0]} : '0;
  end

  dvga_delay_line #(
    .W     (5),
    .DEPTH (PIPE_LAT - 1)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({blank_i, hsync_i, vsync_i, hit1, hit0}),
    .dout ({s2_blank, s2_hsync, s2_vsync, s2_hit1, s2_hit0})
  );

  always_comb begin
    blank_d = s2_blank;
    hsync_d = s2_hsync;
    vsync_d = s2_vsync;
    rgb_d   = pal0_dat_i[23:0];
    if (s2_blank) begin
      rgb_d = 24'h0;
    end else if (s2_hit0 && spr0_dat_i[15]) begin
      rgb_d = rgb555_to_888(spr0_dat_i[14:0]);
    end else if (s2_hit1 && spr1_dat_i[15]) begin
      rgb_d = rgb555_to_888(spr1_dat_i[14:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q  <= 1'b0;
      sh_en_q    <= '0;
      sh_x0_q    <= '0;
      sh_y0_q    <= '0;
      sh_x1_q    <= '0;
      sh_y1_q    <= '0;
      pal_adr_q  <= '0;
      spr0_adr_q <= '0;
      spr1_adr_q <= '0;
      rgb_q      <= '0;
      blank_q    <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      vs_prev_q  <= vs_prev_d;
      sh_en_q    <= sh_en_d;
      sh_x0_q    <= sh_x0_d;
      sh_y0_q    <= sh_y0_d;
      sh_x1_q    <= sh_x1_d;
      sh_y1_q    <= sh_y1_d;
      pal_adr_q  <= pal_adr_d;
      spr0_adr_q <= spr0_adr_d;
      spr1_adr_q <= spr1_adr_d;
      rgb_q      <= rgb_d;
      blank_q    <= blank_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

`ifdef DVGA_SPR_COLLIDE_EN
  logic coll_q, coll_d;

  // Clear has priority over a collision landing on the same clock.
  always_comb begin
    coll_d = coll_q;
    if (ctrl_i[CTRL_COLL_CLR]) begin
      coll_d = 1'b0;
    end else if (s2_hit0 && spr0_dat_i[15] && s2_hit1 && spr1_dat_i[15] && !s2_blank) begin
      coll_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign coll_o = coll_q;
`else
  assign coll_o = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{ctrl_i[31:CTRL_COLL_CLR], pal0_dat_i[31:24],
                         spr0_pos_i[31:POS_Y_MSB+1], spr0_pos_i[POS_Y_LSB-1:POS_X_MSB+1],
                         spr1_pos_i[31:POS_Y_MSB+1], spr1_pos_i[POS_Y_LSB-1:POS_X_MSB+1]};

  assign pal0_adr_o = pal_adr_q;
  assign spr0_adr_o = spr0_adr_q;
  assign spr1_adr_o = spr1_adr_q;
  assign rgb_o      = rgb_q;
  assign blank_o    = blank_q;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;

endmodule

// File: tb/tb_dvga_pixpipe.sv
// Bench for dvga_pixpipe: behavioural BRAM models plus a frame-level reference
// model; define DVGA_SPR_COLLIDE_EN to exercise the collision flag.
module tb_dvga_pixpipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix_dat_i;
  logic [9:0]  pix_x_i, pix_y_i;
  logic        blank_i, hsync_i, vsync_i;
  logic [31:0] ctrl_i, spr0_pos_i, spr1_pos_i;
  logic [7:0]  pal0_adr_o;
  logic [31:0] pal0_dat_i = '0;
  logic [9:0]  spr0_adr_o, spr1_adr_o;
  logic [15:0] spr0_dat_i = '0, spr1_dat_i = '0;
  logic [23:0] rgb_o;
  logic        blank_o, hsync_o, vsync_o, coll_o;

  dvga_pixpipe dut (
    .clk        (clk),
    .rst        (rst),
    .pix_dat_i  (pix_dat_i),
    .pix_x_i    (pix_x_i),
    .pix_y_i    (pix_y_i),
    .blank_i    (blank_i),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .ctrl_i     (ctrl_i),
    .spr0_pos_i (spr0_pos_i),
    .spr1_pos_i (spr1_pos_i),
    .pal0_adr_o (pal0_adr_o),
    .pal0_dat_i (pal0_dat_i),
    .spr0_adr_o (spr0_adr_o),
    .spr0_dat_i (spr0_dat_i),
    .spr1_adr_o (spr1_adr_o),
    .spr1_dat_i (spr1_dat_i),
    .rgb_o      (rgb_o),
    .blank_o    (blank_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .coll_o     (coll_o)
  );

  // Clock and synchronous-read memories (data one clock after address).
  always #5 clk = ~clk;

  logic [31:0] pal_mem  [256];
  logic [15:0] spr0_mem [1024];
  logic [15:0] spr1_mem [1024];

  always @(posedge clk) begin
    pal0_dat_i <= pal_mem[pal0_adr_o];
    spr0_dat_i <= spr0_mem[spr0_adr_o];
    spr1_dat_i <= spr1_mem[spr1_adr_o];
  end

  // Scoreboard: {coll_set, blank, hsync, vsync, rgb} per driven pixel.
  logic [27:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  bit m_en0, m_en1, m_prev_vs, m_coll;
  int m_x0, m_y0, m_x1, m_y1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int spr_off(input int x, input int y, input int px, input int py);
    int dx, dy;
    dx = x - px;
    dy = y - py;
    if (dx < 0 || dx >= 32 || dy < 0 || dy >= 32) return -1;
    return dy * 32 + dx;
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] h);
    int r, g, b;
    r = (int'(h) >> 10) & 31;
    g = (int'(h) >> 5) & 31;
    b = int'(h) & 31;
    return {8'(r * 8 + r / 4), 8'(g * 8 + g / 4), 8'(b * 8 + b / 4)};
  endfunction

  function automatic void model_reset();
    m_en0 = 0; m_en1 = 0; m_prev_vs = 0; m_coll = 0;
    m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
  endfunction

  // Drive one pixel, predict its output, clock once, check addresses and the
  // pixel that entered three clocks earlier.
  task automatic step(input int x, input int y, input int pix, input bit bl, input bit hs, input bit vs);
    int o0, o1;
    logic [15:0] d0, d1;
    logic [23:0] rgb;
    logic [27:0] e;
    bit set, clr;
    pix_x_i = 10'(x); pix_y_i = 10'(y); pix_dat_i = 8'(pix);
    blank_i = bl; hsync_i = hs; vsync_i = vs;
    o0 = m_en0 ? spr_off(x, y, m_x0, m_y0) : -1;
    o1 = m_en1 ? spr_off(x, y, m_x1, m_y1) : -1;
    d0 = (o0 >= 0) ? spr0_mem[o0] : 16'h0;
    d1 = (o1 >= 0) ? spr1_mem[o1] : 16'h0;
    if (bl) rgb = 24'h0;
    else if (o0 >= 0 && d0[15]) rgb = expand(d0);
    else if (o1 >= 0 && d1[15]) rgb = expand(d1);
    else rgb = pal_mem[pix][23:0];
    set = (o0 >= 0) && d0[15] && (o1 >= 0) && d1[15] && !bl;
    exp_q.push_back({set, bl, hs, vs, rgb});
    if (vs && !m_prev_vs) begin
      m_en0 = ctrl_i[0]; m_en1 = ctrl_i[1];
      m_x0 = int'(spr0_pos_i[9:0]); m_y0 = int'(spr0_pos_i[25:16]);
      m_x1 = int'(spr1_pos_i[9:0]); m_y1 = int'(spr1_pos_i[25:16]);
    end
    m_prev_vs = vs;
    clr = ctrl_i[2];
    @(posedge clk);
    #1;
    chk("pal_adr", pal0_adr_o, pix);
    if (o0 >= 0) chk("spr0_adr", spr0_adr_o, o0);
    if (o1 >= 0) chk("spr1_adr", spr1_adr_o, o1);
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk("rgb", rgb_o, e[23:0]);
      chk("vsync", vsync_o, e[24]);
      chk("hsync", hsync_o, e[25]);
      chk("blank", blank_o, e[26]);
`ifdef DVGA_SPR_COLLIDE_EN
      m_coll = clr ? 1'b0 : (m_coll | e[27]);
`else
      m_coll = 1'b0;
`endif
      chk("coll", coll_o, m_coll);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic vs_pulse();
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rgb", rgb_o, 0);
    chk("rst_sync", {blank_o, hsync_o, vsync_o}, 0);
    chk("rst_pal_adr", pal0_adr_o, 0);
    chk("rst_spr_adr", {spr0_adr_o, spr1_adr_o}, 0);
    chk("rst_coll", coll_o, 0);
    exp_q.delete();
    model_reset();
  endtask

  function automatic logic [31:0] pos(input int x, input int y);
    return {6'd0, 10'(y), 6'd0, 10'(x)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) pal_mem[i] = $urandom;
    for (int i = 0; i < 1024; i++) begin
      spr0_mem[i] = 16'($urandom_range(0, 65535));
      spr1_mem[i] = 16'($urandom_range(0, 65535));
    end
    pal_mem[8'h10] = 32'h00101010;
    rst = 1'b1;
    pix_dat_i = '0; pix_x_i = '0; pix_y_i = '0;
    blank_i = 0; hsync_i = 0; vsync_i = 0;
    ctrl_i = '0; spr0_pos_i = '0; spr1_pos_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Palette path only, sprites disabled.
    repeat (3) step(5, 5, 8'h10, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(i, 7, $urandom_range(0, 255), 0, i % 2, 0);

    // Sprite 0 at (100,50): corners and just outside.
    idle(3);
    spr0_mem[0] = 16'hFC00;
    spr0_mem[1023] = 16'h8000 | 16'($urandom_range(0, 32767));
    spr0_pos_i = pos(100, 50);
    ctrl_i = 32'h1;
    vs_pulse();
    step(100, 50, 8'h10, 0, 0, 0);
    step(131, 81, 8'h10, 0, 0, 0);
    step(132, 50, 8'h10, 0, 0, 0);
    step(99, 50, 8'h10, 0, 1, 0);
    step(100, 82, 8'h10, 0, 0, 0);

    // Transparent spr0 over opaque spr1, then the same pixel blanked.
    idle(3);
    spr0_mem[0] = 16'h7FFF;
    spr1_mem[0] = 16'h801F;
    spr1_pos_i = pos(100, 50);
    ctrl_i = 32'h3;
    vs_pulse();
    step(100, 50, 8'h22, 0, 0, 0);
    step(100, 50, 8'h22, 1, 0, 0);
    step(101, 51, 8'h22, 0, 1, 0);

    // Mid-frame position write waits for the next vsync edge.
    spr0_pos_i = pos(200, 50);
    step(100, 50, 8'h10, 0, 0, 0);
    step(200, 50, 8'h10, 0, 0, 0);
    step(131, 81, 8'h10, 0, 0, 0);
    vs_pulse();
    step(100, 50, 8'h10, 0, 0, 0);
    step(200, 50, 8'h10, 0, 0, 0);
    step(231, 81, 8'h10, 0, 0, 0);

    // Right-edge sprite must not wrap to column 0.
    idle(3);
    spr0_mem[31] = 16'hFFFF;
    spr0_pos_i = pos(1000, 50);
    ctrl_i = 32'h1;
    vs_pulse();
    step(1000, 50, 8'h10, 0, 0, 0);
    step(1023, 50, 8'h10, 0, 0, 0);
    for (int c = 0; c < 8; c++) step(c, 50, 8'h10, 0, 0, 0);

    // Overlapping opaque sprites, sticky flag, clear, clear-vs-set.
    idle(3);
    spr0_mem[5 * 32 + 10] = 16'hFFFF;
    spr1_mem[0] = 16'h801F;
    spr0_pos_i = pos(300, 300);
    spr1_pos_i = pos(310, 305);
    ctrl_i = 32'h3;
    vs_pulse();
    step(310, 305, 8'h10, 0, 0, 0);
    idle(4);
    ctrl_i = 32'h7;
    step(0, 0, 0, 1, 0, 0);
    ctrl_i = 32'h3;
    idle(3);
    step(310, 305, 8'h10, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    ctrl_i = 32'h7;
    step(0, 0, 0, 1, 0, 0);
    ctrl_i = 32'h3;
    idle(3);

    // Randomized frames with occasional register updates.
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        ctrl_i = 32'($urandom_range(0, 3));
        spr0_pos_i = pos($urandom_range(0, 90), $urandom_range(0, 90));
        spr1_pos_i = pos($urandom_range(0, 90), $urandom_range(0, 90));
      end
      ctrl_i[2] = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 255),
           $urandom_range(0, 7) == 0, $urandom_range(0, 1), (i % 40) < 2);
    end

    // Reset mid-line: flush, then sprites stay off until the next vsync edge.
    ctrl_i = 32'h3;
    spr0_pos_i = pos(20, 20);
    spr1_pos_i = pos(30, 30);
    vs_pulse();
    for (int i = 0; i < 4; i++) step(25 + i, 25, 8'h10, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(25 + i, 25, 8'h10, 0, 0, 0);
    vs_pulse();
    for (int i = 0; i < 5; i++) step(25 + i, 31, 8'h10, 0, 0, 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
